// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate sign/zero/upper extender behind a 2-entry skid buffer
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] acc_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             in_fire;
    logic             out_fire;
    logic             load_out;
    logic             load_skid;
    logic             move_skid;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic [OUT_W-1:0] out_q;
    logic             out_err_q;
    logic [OUT_W-1:0] skid_data;
    logic             skid_err;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;

    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out_data  = out_q;
    assign out_err   = out_err_q;
    assign acc_count = cnt_q;

    // Extension of the presented immediate; captured only on acceptance.
    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_mode)
            2'b00:   ext_data = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
            2'b01:   ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
            2'b10:   ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
            default: ext_err  = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath steering for the two storage slots.
    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_out   = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (!in_fire && out_fire) begin
                    state_next = EMPTY;
                end else if (in_fire && out_fire) begin
                    load_out   = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    move_skid  = 1'b1;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Output decode: a result is presented whenever the output slot is occupied.
    always_comb begin
        out_valid = (state == ONE) || (state == FULL);
    end

    // in_ready is registered from the next state so it never combinationally follows out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_next != FULL);
        end
    end

    // Output and skid slot storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            out_err_q <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_out) begin
                out_q     <= ext_data;
                out_err_q <= ext_err;
            end else if (move_skid) begin
                out_q     <= skid_data;
                out_err_q <= skid_err;
            end
            if (load_skid) begin
                skid_data <= ext_data;
                skid_err  <= ext_err;
            end
        end
    end

    // Accepted-transaction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [7:0]  acc_count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [0:0]  s_in_imm;
    logic [1:0]  s_in_mode;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic        s_out_err;
    logic [7:0]  s_acc_count;

    int tests  = 0;
    int errors = 0;
    int exp_cnt;
    int bad;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] imm;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .acc_count (acc_count)
    );

    imm_extend_pipe #(.IN_W(1), .OUT_W(8), .CNT_W(8)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_imm    (s_in_imm),
        .in_mode   (s_in_mode),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .out_err   (s_out_err),
        .acc_count (s_acc_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{2'b00, 16'h8001, 32'hFFFF8001, 1'b0};
        vecs[1] = '{2'b01, 16'h8001, 32'h00008001, 1'b0};
        vecs[2] = '{2'b10, 16'h1234, 32'h12340000, 1'b0};
        vecs[3] = '{2'b11, 16'h1234, 32'h00000000, 1'b1};
        vecs[4] = '{2'b00, 16'h7FFF, 32'h00007FFF, 1'b0};
        vecs[5] = '{2'b10, 16'hFFFF, 32'hFFFF0000, 1'b0};
        vecs[6] = '{2'b01, 16'hFFFF, 32'h0000FFFF, 1'b0};
        vecs[7] = '{2'b00, 16'h0000, 32'h00000000, 1'b0};

        rst         = 1'b1;
        in_valid    = 1'b1;
        in_imm      = 16'hABCD;
        in_mode     = 2'b00;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_imm    = 1'b0;
        s_in_mode   = 2'b00;
        s_out_ready = 1'b1;

        // Reset state, with in_valid asserted throughout.
        step();
        step();
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_out_err",   {31'd0, out_err},   32'd0);
        chk("rst_acc_count", {24'd0, acc_count}, 32'd0);

        rst = 1'b0;
        step();
        chk("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("post_rst_no_accept", {24'd0, acc_count}, 32'd0);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        step();
        exp_cnt = 0;

        // Table-driven extension checks, one transaction at a time.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_imm   = vecs[i].imm;
            in_mode  = vecs[i].mode;
            step();
            in_valid = 1'b0;
            in_imm   = ~vecs[i].imm;
            in_mode  = 2'b01;
            exp_cnt++;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_data", i),  out_data,           vecs[i].data);
            chk($sformatf("vec%0d_err", i),   {31'd0, out_err},   {31'd0, vecs[i].err});
            step();
            chk($sformatf("vec%0d_drain", i), {31'd0, out_valid}, 32'd0);
        end
        chk("vec_acc_count", {24'd0, acc_count}, exp_cnt);

        // Backpressure: A and B fill the buffer, C waits.
        out_ready = 1'b0;
        in_mode   = 2'b01;
        in_valid  = 1'b1;
        in_imm    = 16'h00AA;
        step();
        chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
        in_imm = 16'h00BB;
        step();
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        in_imm = 16'h00CC;
        step();
        chk("bp_hold_ready", {31'd0, in_ready},  32'd0);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_a",     out_data,           32'h000000AA);
        step();
        chk("bp_stable_a",   out_data,           32'h000000AA);
        chk("bp_cnt_full",   {24'd0, acc_count}, exp_cnt + 2);
        out_ready = 1'b1;
        step();
        chk("bp_out_b", out_data, 32'h000000BB);
        step();
        in_valid = 1'b0;
        chk("bp_out_c", out_data, 32'h000000CC);
        chk("bp_valid_c", {31'd0, out_valid}, 32'd1);
        step();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_cnt", {24'd0, acc_count}, exp_cnt + 3);

        // Streaming: 300 back-to-back inputs from a fresh count.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bad = 0;
        in_valid = 1'b1;
        in_mode  = 2'b01;
        for (int i = 0; i < 300; i++) begin
            in_imm = 16'(i);
            step();
            if (!(out_valid === 1'b1 && out_data === 32'(i) && in_ready === 1'b1)) bad++;
        end
        in_valid = 1'b0;
        chk("stream_mismatches", bad, 32'd0);
        chk("stream_acc_count", {24'd0, acc_count}, 32'd44);
        step();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Reset while FULL discards both buffered results.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_imm    = 16'h1111;
        step();
        in_imm = 16'h2222;
        step();
        in_valid = 1'b0;
        chk("full_before_rst", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("full_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("full_rst_cnt",   {24'd0, acc_count}, 32'd0);
        chk("full_rst_data",  out_data,           32'd0);
        step();
        chk("full_rst_ready", {31'd0, in_ready}, 32'd1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) bad++;
            step();
        end
        chk("full_rst_no_stale", bad, 32'd0);

        // Narrow instance: IN_W=1, OUT_W=8.
        s_in_valid = 1'b1;
        s_in_imm   = 1'b1;
        s_in_mode  = 2'b00;
        step();
        s_in_mode = 2'b10;
        chk("small_sext", {24'd0, s_out_data}, 32'h000000FF);
        step();
        s_in_mode = 2'b01;
        chk("small_upper", {24'd0, s_out_data}, 32'h00000080);
        step();
        s_in_valid = 1'b0;
        chk("small_zext", {24'd0, s_out_data}, 32'h00000001);
        chk("small_cnt", {24'd0, s_acc_count}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, width of the immediate field to extend; legal range 1..OUT_W-1.
REQ-002 Parameter OUT_W, default 32, datapath width of the extended result.
REQ-003 Parameter CNT_W, default 8, width of the accepted-transaction counter.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_valid  input  1  producer presents a valid immediate.
REQ-007 Port in_ready  output  1  block can accept an immediate this cycle.
REQ-008 Port in_imm  input  IN_W  immediate to extend.
REQ-009 Port in_mode  input  2  00 sign-extend, 01 zero-extend, 10 upper-place, 11 illegal.
REQ-010 Port out_valid  output  1  out_data/out_err hold a valid result.
REQ-011 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 Port out_data  output  OUT_W  extended result.
REQ-013 Port out_err  output  1  result came from an illegal mode.
REQ-014 Port acc_count  output  CNT_W  number of accepted inputs, modulo 2^CNT_W.

Function
REQ-015 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-016 Mode 00 SHALL produce out_data[IN_W-1:0] = in_imm, with bits [OUT_W-1:IN_W] each equal to in_imm[IN_W-1].
REQ-017 Mode 01 SHALL produce out_data[IN_W-1:0] = in_imm, with bits [OUT_W-1:IN_W] set to 0.
REQ-018 Mode 10 SHALL produce out_data[OUT_W-1:OUT_W-IN_W] = in_imm, with the lower OUT_W-IN_W bits set to 0.
REQ-019 Mode 11 SHALL produce out_data = 0 and out_err = 1; in all other modes out_err = 0.
REQ-020 Extension SHALL be computed at acceptance and stored; later changes to in_imm/in_mode do not affect stored results.
REQ-021 Storage SHALL be a 2-entry skid buffer (output register plus skid register) with FSM states EMPTY, ONE and FULL.
REQ-022 EMPTY: an input transfer loads the output register -> ONE; otherwise stay in EMPTY.
REQ-023 ONE: input without output transfer loads skid -> FULL; output without input -> EMPTY; both -> load output register, stay ONE; neither -> stay ONE.
REQ-024 FULL: an output transfer moves skid to the output register -> ONE; otherwise stay in FULL.
REQ-025 in_ready SHALL be registered: 1 in EMPTY/ONE, 0 in FULL; in_valid in FULL is ignored.
REQ-026 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY; latency from input transfer to out_valid is exactly 1 cycle when EMPTY.
REQ-027 Results SHALL leave in acceptance order; no result is dropped or duplicated.
REQ-028 out_data/out_err SHALL hold stable while out_valid && !out_ready.
REQ-029 acc_count SHALL increment by 1 on every input transfer and wrap from 2^CNT_W-1 to 0.
REQ-030 With out_ready held 1 and in_valid held 1, throughput SHALL be one result per cycle.

Reset
REQ-031 While rst=1 at a clock edge: state EMPTY, in_ready=0, out_valid=0, out_data=0, out_err=0, acc_count=0, skid contents cleared.
REQ-032 First edge after rst deasserts SHALL set in_ready=1; inputs presented while rst=1 are not accepted.
REQ-033 rst asserted in ONE or FULL SHALL discard all buffered results without any output transfer.

Verification
REQ-034 Defaults; mode 00 imm 16'h8001, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF8001, out_err=0.
REQ-035 Mode 01 imm 16'h8001 -> 32'h00008001; mode 10 imm 16'h1234 -> 32'h12340000; mode 11 -> 32'h0, out_err=1.
REQ-036 out_ready=0 and three back-to-back inputs A,B,C -> A,B accepted, in_ready=0 in FULL, C held; release out_ready -> outputs A,B,C in order.
REQ-037 Continuous in_valid/out_ready for 300 inputs with CNT_W=8 -> one result per cycle, acc_count=44 (300 mod 256).
REQ-038 rst pulse while FULL -> next cycle out_valid=0, acc_count=0; the following cycle in_ready=1, and no stale result ever appears.
REQ-039 IN_W=1, OUT_W=8, mode 00 imm 1 -> 8'hFF; mode 10 imm 1 -> 8'h80.
